// File: rtl/cr_kme_fifo_wr_packer_if.sv
// Stream + FIFO-write bundle for the KME write-side packer.
// master: word source / FIFO side. slave: the packer itself.
interface cr_kme_fifo_wr_packer_if #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 128
);
  logic             in_valid;
  logic [IN_W-1:0]  in_data;
  logic             in_last;
  logic             in_ready;
  logic [OUT_W-1:0] fifo_in;
  logic             fifo_in_valid;
  logic             fifo_in_stall;

  modport master (
    output in_valid, in_data, in_last, fifo_in_stall,
    input  in_ready, fifo_in, fifo_in_valid
  );

  modport slave (
    input  in_valid, in_data, in_last, fifo_in_stall,
    output in_ready, fifo_in, fifo_in_valid
  );
endinterface

// File: rtl/cr_kme_fifo_wr_packer.sv
// Packs RATIO words of IN_W bits into one OUT_W-bit FIFO entry (lane 0 = LSBs).
// in_last closes an entry early; unfilled lanes are zero. One entry may be
// pending; close and push in the same cycle give full throughput.
// OUT_W must equal IN_W*RATIO; RATIO is a power of two >= 2.
// Optional: define CR_KME_PACKER_STAT_EN to add saturating stall_cnt/pad_cnt.
module cr_kme_fifo_wr_packer #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 128,
  parameter int RATIO = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  cr_kme_fifo_wr_packer_if.slave   bus,
`ifdef CR_KME_PACKER_STAT_EN
  output logic [15:0]              stall_cnt,
  output logic [15:0]              pad_cnt,
`endif
  output logic                     idle
);

  localparam int CW = $clog2(RATIO);

  logic [CW-1:0]    lane_cnt_q, lane_cnt_d;
  logic [OUT_W-1:0] asm_q, asm_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic             out_pend_q, out_pend_d;

  logic             push;
  logic             ready;
  logic             acc;
  logic             close;
  logic             last_lane;
  logic [OUT_W-1:0] merged;

  // Handshake gating, word merge and next-state for the assembly/out registers
  always_comb begin
    push      = out_pend_q & ~bus.fifo_in_stall;
    ready     = ~out_pend_q | push;
    acc       = bus.in_valid & ready;
    last_lane = (lane_cnt_q == CW'(RATIO - 1));
    close     = acc & (last_lane | bus.in_last);

    merged = asm_q;
    for (int k = 0; k < RATIO; k++) begin
      if (lane_cnt_q == CW'(k)) merged[IN_W*k +: IN_W] = bus.in_data;
    end

    lane_cnt_d = lane_cnt_q;
    asm_d      = asm_q;
    out_d      = out_q;
    out_pend_d = out_pend_q;

    if (push) out_pend_d = 1'b0;

    if (close) begin
      out_d      = merged;
      out_pend_d = 1'b1;
      lane_cnt_d = '0;
      asm_d      = '0;
    end else if (acc) begin
      asm_d      = merged;
      lane_cnt_d = lane_cnt_q + CW'(1);
    end
  end

  // Assembly and output register update
  always_ff @(posedge clk) begin
    if (rst) begin
      lane_cnt_q <= '0;
      asm_q      <= '0;
      out_q      <= '0;
      out_pend_q <= 1'b0;
    end else begin
      lane_cnt_q <= lane_cnt_d;
      asm_q      <= asm_d;
      out_q      <= out_d;
      out_pend_q <= out_pend_d;
    end
  end

  assign bus.in_ready      = ready;
  assign bus.fifo_in_valid = push;
  assign bus.fifo_in       = out_q;
  assign idle              = (lane_cnt_q == '0) & ~out_pend_q;

`ifdef CR_KME_PACKER_STAT_EN
  logic [15:0] stall_cnt_q;
  logic [15:0] pad_cnt_q;

  // Saturating counters: stalled-pending cycles and entries closed short by in_last
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      pad_cnt_q   <= '0;
    end else begin
      if (out_pend_q & bus.fifo_in_stall & (stall_cnt_q != 16'hFFFF))
        stall_cnt_q <= stall_cnt_q + 16'd1;
      if (close & ~last_lane & (pad_cnt_q != 16'hFFFF))
        pad_cnt_q <= pad_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign pad_cnt   = pad_cnt_q;
`endif

endmodule

// File: tb/tb_cr_kme_fifo_wr_packer.sv
// Self-checking bench for cr_kme_fifo_wr_packer: directed vector table,
// hand-written multi-cycle sequences, and randomized traffic against a
// word-queue reference model.
module tb_cr_kme_fifo_wr_packer;

  localparam int IN_W  = 32;
  localparam int OUT_W = 128;
  localparam int RATIO = 4;

  logic clk = 1'b0;
  logic rst;
  logic idle;
`ifdef CR_KME_PACKER_STAT_EN
  logic [15:0] stall_cnt;
  logic [15:0] pad_cnt;
`endif

  cr_kme_fifo_wr_packer_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  cr_kme_fifo_wr_packer #(.IN_W(IN_W), .OUT_W(OUT_W), .RATIO(RATIO)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
`ifdef CR_KME_PACKER_STAT_EN
    .stall_cnt (stall_cnt),
    .pad_cnt   (pad_cnt),
`endif
    .idle (idle)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int mon_push = 0;
  int ovf = 0;

  // FIFO-side observer: count writes and any write while stalled
  always @(posedge clk) begin
    if (!rst) begin
      if (bus.fifo_in_valid) mon_push++;
      if (bus.fifo_in_valid && bus.fifo_in_stall) ovf++;
    end
  end

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkw(input string nm, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: words collected for the open entry, closed entries
  // awaiting a FIFO write, and the most recently closed entry.
  logic [IN_W-1:0]  mw[$];
  logic [OUT_W-1:0] mq[$];
  logic [OUT_W-1:0] mout;

  task automatic model_clear();
    mw.delete();
    mq.delete();
    mout = '0;
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model
  task automatic cyc(input logic v, input logic [IN_W-1:0] d, input logic l, input logic s,
                     output logic acc);
    logic             ev, er, ei;
    logic [OUT_W-1:0] e;
    bus.in_valid      = v;
    bus.in_data       = d;
    bus.in_last       = l;
    bus.fifo_in_stall = s;
    #3;
    ev = (mq.size() != 0) && !s;
    er = (mq.size() == 0) || ev;
    ei = (mw.size() == 0) && (mq.size() == 0);
    chk1("in_ready", bus.in_ready, er);
    chk1("fifo_in_valid", bus.fifo_in_valid, ev);
    chk1("idle", idle, ei);
    chkw("fifo_in", bus.fifo_in, mout);
    if (ev) void'(mq.pop_front());
    acc = v && er;
    if (acc) begin
      mw.push_back(d);
      if (mw.size() == RATIO || l) begin
        e = '0;
        foreach (mw[i]) e[IN_W*i +: IN_W] = mw[i];
        mq.push_back(e);
        mout = e;
        mw.delete();
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_rst();
    bus.in_valid      = 1'b0;
    bus.in_last       = 1'b0;
    bus.in_data       = '0;
    bus.fifo_in_stall = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.fifo_in_stall = 1'b0;
    model_clear();
    #2;
    chk1("rst_idle", idle, 1'b1);
    chk1("rst_fifo_in_valid", bus.fifo_in_valid, 1'b0);
    chk1("rst_in_ready", bus.in_ready, 1'b1);
    chkw("rst_fifo_in", bus.fifo_in, '0);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic             v;
    logic [IN_W-1:0]  d;
    logic             l;
    logic             s;
    logic             er;
    logic             ev;
    logic [OUT_W-1:0] ef;
    logic             ei;
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic acc;
    int   idx, p0, nacc;
    logic [IN_W-1:0] w[8];

    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_last = 1'b0;
    bus.fifo_in_stall = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    do_rst();

    // Directed table: four-word entry, then short in_last entry, then a stalled entry
    tbl[0] = '{1'b1, 32'h11111111, 1'b0, 1'b0, 1'b1, 1'b0, 128'h0, 1'b1};
    tbl[1] = '{1'b1, 32'h22222222, 1'b0, 1'b0, 1'b1, 1'b0, 128'h0, 1'b0};
    tbl[2] = '{1'b1, 32'h33333333, 1'b0, 1'b0, 1'b1, 1'b0, 128'h0, 1'b0};
    tbl[3] = '{1'b1, 32'h44444444, 1'b0, 1'b0, 1'b1, 1'b0, 128'h0, 1'b0};
    tbl[4] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1,
               128'h44444444_33333333_22222222_11111111, 1'b0};
    tbl[5] = '{1'b1, 32'h0000000A, 1'b0, 1'b0, 1'b1, 1'b0,
               128'h44444444_33333333_22222222_11111111, 1'b1};
    tbl[6] = '{1'b1, 32'h0000000B, 1'b1, 1'b0, 1'b1, 1'b0,
               128'h44444444_33333333_22222222_11111111, 1'b0};
    tbl[7] = '{1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 1'b0,
               128'h00000000_00000000_0000000B_0000000A, 1'b0};
    tbl[8] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1,
               128'h00000000_00000000_0000000B_0000000A, 1'b0};
    tbl[9] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0,
               128'h00000000_00000000_0000000B_0000000A, 1'b1};

    for (int i = 0; i < 10; i++) begin
      bus.in_valid      = tbl[i].v;
      bus.in_data       = tbl[i].d;
      bus.in_last       = tbl[i].l;
      bus.fifo_in_stall = tbl[i].s;
      #3;
      chk1($sformatf("tbl%0d_in_ready", i), bus.in_ready, tbl[i].er);
      chk1($sformatf("tbl%0d_fifo_in_valid", i), bus.fifo_in_valid, tbl[i].ev);
      chkw($sformatf("tbl%0d_fifo_in", i), bus.fifo_in, tbl[i].ef);
      chk1($sformatf("tbl%0d_idle", i), idle, tbl[i].ei);
      @(posedge clk);
      #1;
    end

    // Stall held 10 cycles while 8 words are offered
    do_rst();
    for (int i = 0; i < 8; i++) w[i] = 32'h1000_0000 + i;
    idx = 0;
    p0 = mon_push;
    for (int c = 0; c < 30; c++) begin
      cyc(idx < 8, (idx < 8) ? w[idx] : '0, 1'b0, c < 10, acc);
      if (acc) idx++;
    end
    chk1("stall_all_words_taken", idx == 8, 1'b1);
    chkw("stall_push_count", OUT_W'(mon_push - p0), OUT_W'(2));

    // Continuous 32-word stream: one entry every 4 cycles, never back-pressured
    do_rst();
    p0 = mon_push;
    nacc = 0;
    for (int i = 0; i < 32; i++) begin
      cyc(1'b1, $urandom, 1'b0, 1'b0, acc);
      if (acc) nacc++;
    end
    cyc(1'b0, '0, 1'b0, 1'b0, acc);
    chkw("stream_accepts", OUT_W'(nacc), OUT_W'(32));
    chkw("stream_push_count", OUT_W'(mon_push - p0), OUT_W'(8));

    // Reset with a pending entry, then with a partial entry
    do_rst();
    p0 = mon_push;
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'hC0DE_0000 + i, 1'b0, 1'b1, acc);
    do_rst();
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'hBAD0_0000 + i, 1'b0, 1'b0, acc);
    do_rst();
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'h5A5A_0000 + i, 1'b0, 1'b0, acc);
    repeat (3) cyc(1'b0, '0, 1'b0, 1'b0, acc);
    chkw("rst_then_one_entry", OUT_W'(mon_push - p0), OUT_W'(1));

    // in_last with in_valid low must not close anything
    do_rst();
    cyc(1'b1, 32'h77, 1'b0, 1'b0, acc);
    cyc(1'b0, '0, 1'b1, 1'b0, acc);
    cyc(1'b1, 32'h88, 1'b1, 1'b0, acc);
    repeat (2) cyc(1'b0, '0, 1'b0, 1'b0, acc);
    chkw("last_without_valid", bus.fifo_in, 128'h00000000_00000000_00000088_00000077);

    // Randomized traffic against the model
    do_rst();
    for (int c = 0; c < 1500; c++)
      cyc(($urandom % 4) != 0, $urandom, ($urandom % 5) == 0, ($urandom % 3) == 0, acc);
    repeat (4) cyc(1'b0, '0, 1'b0, 1'b0, acc);

`ifdef CR_KME_PACKER_STAT_EN
    do_rst();
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'h9000_0000 + i, 1'b0, 1'b0, acc);
    repeat (5) cyc(1'b0, '0, 1'b0, 1'b1, acc);
    cyc(1'b0, '0, 1'b0, 1'b0, acc);
    cyc(1'b1, 32'hA1, 1'b0, 1'b0, acc);
    cyc(1'b1, 32'hB2, 1'b1, 1'b0, acc);
    cyc(1'b0, '0, 1'b0, 1'b0, acc);
    chkw("stall_cnt", OUT_W'(stall_cnt), OUT_W'(5));
    chkw("pad_cnt", OUT_W'(pad_cnt), OUT_W'(1));
`endif

    chkw("overflow_writes", OUT_W'(ovf), OUT_W'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
